// File: rtl/adau_pkg.sv
// Shared constants for the ADAU codec serial paths (playback and capture).
package adau_pkg;

    // Default bits per channel, MSB first on the wire
    localparam int unsigned ADAU_SAMPLE_WIDTH = 24;
    // Stereo frame as {left, right}
    localparam int unsigned ADAU_FRAME_WIDTH  = 2 * ADAU_SAMPLE_WIDTH;

    // I2S slot-state encoding
    localparam logic [1:0] SLOT_ALIGN = 2'd0;
    localparam logic [1:0] SLOT_LEFT  = 2'd1;
    localparam logic [1:0] SLOT_RIGHT = 2'd2;

endpackage

// File: rtl/audio_rx_fifo.sv
// First-word fall-through FIFO for captured stereo frames. A push while full is
// accepted only when a pop happens in the same cycle.
module audio_rx_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_wr_en,
    input  logic [WIDTH-1:0]             i_wr_data,
    input  logic                         i_rd_en,
    output logic [WIDTH-1:0]             o_rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_fill,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FillW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [FillW-1:0] r_fill;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_fill == FillW'(DEPTH));
    assign o_empty   = (r_fill == '0);
    assign w_pop     = i_rd_en && !o_empty;
    assign w_push    = i_wr_en && (!o_full || w_pop);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_fill    = r_fill;

    // Storage; cleared on reset so the head reads as zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + FillW'(1);
            end else if (w_pop && !w_push) begin
                r_fill <= r_fill - FillW'(1);
            end
        end
    end

endmodule

// File: rtl/adau_audio_rx.sv
// I2S capture from the ADAU ADC: input synchronisers, bclk edge detect, slot FSM,
// frame assembly into a FWFT FIFO and sticky error flags.
module adau_audio_rx
    import adau_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = ADAU_SAMPLE_WIDTH,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              enable,
    input  logic                              bclk,
    input  logic                              lrclk,
    input  logic                              adc_sdata,
    output logic [2*SAMPLE_WIDTH-1:0]         audio_out,
    output logic                              audio_out_valid,
    input  logic                              audio_out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill,
    output logic                              overflow,
    output logic                              frame_err,
    input  logic                              clear_flags
);

    localparam int unsigned CntW = $clog2(SAMPLE_WIDTH + 1);

    logic [SYNC_STAGES-1:0]  r_bclk_sync;
    logic [SYNC_STAGES-1:0]  r_lr_sync;
    logic [SYNC_STAGES-1:0]  r_sd_sync;
    logic                    r_bclk_prev;
    logic                    r_lr_prev;
    logic [1:0]              r_state;
    logic [CntW-1:0]         r_cnt;
    logic [SAMPLE_WIDTH-1:0] r_left;
    logic [SAMPLE_WIDTH-1:0] r_right;
    logic                    r_left_done;
    logic                    r_skip;
    logic                    r_overflow;
    logic                    r_frame_err;

    logic w_bclk_s;
    logic w_lrclk_s;
    logic w_sdata_s;
    logic w_bclk_rise;
    logic w_lr_change;
    logic w_cnt_full;
    logic w_commit;
    logic w_frame_ok;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_ovf_evt;
    logic w_short_evt;

    assign w_bclk_s    = r_bclk_sync[SYNC_STAGES-1];
    assign w_lrclk_s   = r_lr_sync[SYNC_STAGES-1];
    assign w_sdata_s   = r_sd_sync[SYNC_STAGES-1];
    assign w_bclk_rise = w_bclk_s && !r_bclk_prev;
    assign w_lr_change = w_bclk_rise && (w_lrclk_s != r_lr_prev);
    assign w_cnt_full  = (r_cnt == CntW'(SAMPLE_WIDTH));

    // Commit happens on the RIGHT->LEFT change; r_skip marks a first partial RIGHT slot
    assign w_commit    = enable && w_lr_change && (r_state == SLOT_RIGHT);
    assign w_frame_ok  = r_left_done && w_cnt_full;
    assign w_push      = w_commit && w_frame_ok;
    assign w_short_evt = w_commit && !w_frame_ok && !r_skip;
    assign w_pop       = audio_out_valid && audio_out_ready;
    assign w_ovf_evt   = w_push && w_full && !w_pop;

    assign audio_out_valid = !w_empty;
    assign overflow        = r_overflow;
    assign frame_err       = r_frame_err;

    // Resynchronise the serial inputs into the clk domain
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bclk_sync <= '0;
            r_lr_sync   <= '0;
            r_sd_sync   <= '0;
        end else begin
            r_bclk_sync[0] <= bclk;
            r_lr_sync[0]   <= lrclk;
            r_sd_sync[0]   <= adc_sdata;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_bclk_sync[i] <= r_bclk_sync[i-1];
                r_lr_sync[i]   <= r_lr_sync[i-1];
                r_sd_sync[i]   <= r_sd_sync[i-1];
            end
        end
    end

    // Edge history: previous bclk sample and lrclk as seen at the last bclk rise
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bclk_prev <= 1'b0;
            r_lr_prev   <= 1'b0;
        end else begin
            r_bclk_prev <= w_bclk_s;
            if (w_bclk_rise) begin
                r_lr_prev <= w_lrclk_s;
            end
        end
    end

    // Slot FSM and channel shift registers; the change bit is the I2S delay bit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= SLOT_ALIGN;
            r_cnt       <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_left_done <= 1'b0;
            r_skip      <= 1'b0;
        end else if (!enable) begin
            r_state     <= SLOT_ALIGN;
            r_cnt       <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_left_done <= 1'b0;
            r_skip      <= 1'b0;
        end else if (w_bclk_rise) begin
            if (w_lr_change) begin
                r_cnt <= '0;
                case (r_state)
                    SLOT_ALIGN: begin
                        r_state     <= w_lrclk_s ? SLOT_RIGHT : SLOT_LEFT;
                        r_skip      <= w_lrclk_s;
                        r_left_done <= 1'b0;
                    end
                    SLOT_LEFT: begin
                        r_state     <= SLOT_RIGHT;
                        r_left_done <= w_cnt_full;
                    end
                    default: begin
                        r_state     <= SLOT_LEFT;
                        r_skip      <= 1'b0;
                        r_left_done <= 1'b0;
                    end
                endcase
            end else if ((r_state != SLOT_ALIGN) && !w_cnt_full) begin
                r_cnt <= r_cnt + CntW'(1);
                if (r_state == SLOT_LEFT) begin
                    r_left <= {r_left[SAMPLE_WIDTH-2:0], w_sdata_s};
                end else begin
                    r_right <= {r_right[SAMPLE_WIDTH-2:0], w_sdata_s};
                end
            end
        end
    end

    // Sticky flags; a new event wins over a simultaneous clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_evt   || (r_overflow  && !clear_flags);
            r_frame_err <= w_short_evt || (r_frame_err && !clear_flags);
        end
    end

    audio_rx_fifo #(
        .WIDTH (2 * SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (clk),
        .i_rst_n   (resetn),
        .i_wr_en   (w_push),
        .i_wr_data ({r_left, r_right}),
        .i_rd_en   (audio_out_ready),
        .o_rd_data (audio_out),
        .o_fill    (fill),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

endmodule
